qadd_arbiter: RTL

Round-robin scheduler that shares one registered sign-magnitude fixed-point adder (`qadd`) between `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle and feeds its pair to the adder. Results come back through a 2-entry output FIFO, tagged with the requester ID, zero-normalized and flagged on overflow. It sits between independent DSP channels and the single adder instance they share.

---
 rtl/dsp_bb_pkg.sv | 7 +
 rtl/qadd.sv | 31 +++
 rtl/qadd_arbiter.sv | 86 ++++++++
 3 files changed

// File: rtl/dsp_bb_pkg.sv
// dsp_bb_pkg: shared constants and helpers for the DSP building blocks
package dsp_bb_pkg;
  localparam int QADD_LATENCY = 1;
  function automatic int entry_w(input int n, input int idw);
    return n + idw + 1;
  endfunction
endpackage

// File: rtl/qadd.sv
// qadd: registered sign-magnitude fixed-point adder, one cycle latency
module qadd
  import dsp_bb_pkg::*;
#(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_sum
);
  logic         sa, sb;
  logic [N-2:0] ma, mb;
  logic [N-1:0] sum_d, sum_q;
  if (Q < 0 || Q > N - 1) begin : g_q_range
    $error("qadd: Q must lie in 0..N-1");
  end
  assign {sa, ma} = i_a;
  assign {sb, mb} = i_b;
  // Magnitudes add modulo 2^(N-1); mixed signs take the larger magnitude's sign
  always_comb begin
    sum_d = (sa == sb) ? {sa, ma + mb} : (ma >= mb) ? {sa, ma - mb} : {sb, mb - ma};
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sum_q <= '0;
    else sum_q <= sum_d;
  end
  assign o_sum = sum_q;
endmodule

// File: rtl/qadd_arbiter.sv
// qadd_arbiter: round-robin sharing of one qadd among NREQ requesters,
// results returned in grant order through a 2-entry tagged FIFO.
module qadd_arbiter
  import dsp_bb_pkg::*;
#(
  parameter int Q = 15,
  parameter int N = 32,
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req_valid,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [NREQ*N-1:0] i_req_a,
  input  logic [NREQ*N-1:0] i_req_b,
  output logic              o_res_valid,
  output logic [N-1:0]      o_res_data,
  output logic [IDW-1:0]    o_res_id,
  output logic              o_res_ovf,
  input  logic              i_res_ready
);
  localparam int EW = entry_w(N, IDW);
  logic [IDW-1:0] last_q, grant_id, idx, s1_id_q;
  logic           grant_any, can_issue, pop, push, s1_valid_q, s1_ovf_q, s1_ovf_d, s1_zero;
  logic [1:0]     cnt_q, cnt_d;
  logic [N-1:0]   a_mux, b_mux, sum;
  logic [EW-1:0]  mem_q [2];
  logic [EW-1:0]  wdata;
  logic           wr_q, rd_q;
  assign o_res_valid = cnt_q != 2'd0;
  assign pop = o_res_valid & i_res_ready;
  assign push = s1_valid_q;
  assign cnt_d = cnt_q + 2'(push) - 2'(pop);
  // Results granted but not yet popped live either in s1 or in the FIFO
  assign can_issue = !i_rst && (({1'b0, cnt_q} + 3'(s1_valid_q) - 3'(pop)) < 3'd2);
  always_comb begin
    grant_any = 1'b0;
    grant_id = '0;
    idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((int'(last_q) + i) % NREQ);
      if (!grant_any && can_issue && i_req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id = idx;
      end
    end
  end
  assign o_req_ready = grant_any ? (NREQ'(1) << grant_id) : '0;
  assign a_mux = grant_any ? i_req_a[grant_id*N +: N] : '0;
  assign b_mux = grant_any ? i_req_b[grant_id*N +: N] : '0;
  // Carry out of the magnitude add happens exactly when a_mag exceeds ~b_mag
  assign s1_ovf_d = (a_mux[N-1] == b_mux[N-1]) && (a_mux[N-2:0] > ~b_mux[N-2:0]);
  qadd #(.Q(Q), .N(N)) u_qadd (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_a  (a_mux),
    .i_b  (b_mux),
    .o_sum(sum)
  );
  assign s1_zero = (sum[N-2:0] == '0) && !s1_ovf_q;
  assign wdata = {s1_zero ? '0 : sum, s1_id_q, s1_ovf_q};
  assign {o_res_data, o_res_id, o_res_ovf} = mem_q[rd_q];
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_q <= IDW'(NREQ - 1);
      s1_valid_q <= 1'b0;
      s1_id_q <= '0;
      s1_ovf_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (grant_any) last_q <= grant_id;
      s1_valid_q <= grant_any;
      s1_id_q <= grant_id;
      s1_ovf_q <= s1_ovf_d;
      if (push) mem_q[wr_q] <= wdata;
      wr_q <= wr_q ^ push;
      rd_q <= rd_q ^ pop;
      cnt_q <= cnt_d;
    end
  end
endmodule
